ads5404_sync_align: RTL

- Parametrised post-IDDR alignment stage for multi-channel 2-sample-per-clock DDR ADC interfaces.
- Sits between the per-pin IDDR de-interleave and user logic.
- Uses the ADC syncout stream to find the sample phase, swaps or delays half-words so the sync sample always lands in lane 0, and checks sync periodicity.
- Keeps sticky and counted overrange status per channel.

---
 rtl/ads5404_sync_align.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ads5404_sync_align.sv
// Post-IDDR alignment for 2-sample-per-clock DDR ADC channels: finds the syncout phase,
// realigns samples so the sync sample lands in lane 0, checks sync period, tracks overrange.
module ads5404_sync_align #(
  parameter int NCHAN       = 2,
  parameter int NBITS       = 12,
  parameter int SYNC_PERIOD = 0,
  parameter int ERR_W       = 8,
  parameter int OVR_CNT_W   = 16
) (
  input  logic                       adc_clk,
  input  logic                       user_rst,
  input  logic                       arm,
  input  logic                       ovr_clear,
  input  logic [NCHAN*NBITS-1:0]     din_0,
  input  logic [NCHAN*NBITS-1:0]     din_1,
  input  logic [NCHAN-1:0]           ovr_in_0,
  input  logic [NCHAN-1:0]           ovr_in_1,
  input  logic                       sync_in_0,
  input  logic                       sync_in_1,
  output logic [NCHAN*NBITS-1:0]     dout_0,
  output logic [NCHAN*NBITS-1:0]     dout_1,
  output logic [NCHAN-1:0]           ovr_out_0,
  output logic [NCHAN-1:0]           ovr_out_1,
  output logic                       sync_out,
  output logic [1:0]                 state,
  output logic                       phase,
  output logic [ERR_W-1:0]           err_count,
  output logic [NCHAN-1:0]           ovr_sticky,
  output logic [NCHAN*OVR_CNT_W-1:0] ovr_count
);

  localparam int CNT_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SYNC_PERIOD > 0) ? SYNC_PERIOD - 1 : 0);
  localparam bit CHECK_EN = (SYNC_PERIOD != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  typedef struct packed {
    logic [NCHAN*NBITS-1:0] s0;
    logic [NCHAN*NBITS-1:0] s1;
    logic [NCHAN-1:0]       o0;
    logic [NCHAN-1:0]       o1;
    logic                   y0;
    logic                   y1;
  } word_t;

  word_t                  in_word;
  word_t                  d1_reg;
  logic [NCHAN*NBITS-1:0] d2_s1_reg;
  logic [NCHAN-1:0]       d2_o1_reg;
  logic                   d2_y1_reg;
  logic                   prev_sync_1_reg;
  logic                   out_y1_reg;

  logic [NCHAN*NBITS-1:0] lane0_d, lane1_d;
  logic [NCHAN-1:0]       lane0_o, lane1_o;
  logic                   lane0_y, lane1_y;

  state_t                 state_reg;
  logic                   phase_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   edge0, edge1, edge_any;

  logic [NCHAN-1:0]       ovr_hit;
  logic [NCHAN-1:0]       ovr_sticky_reg;
  logic [OVR_CNT_W-1:0]   ovr_cnt_reg [NCHAN];

  assign in_word  = {din_0, din_1, ovr_in_0, ovr_in_1, sync_in_0, sync_in_1};
  assign edge0    = sync_in_0 & ~prev_sync_1_reg;
  assign edge1    = sync_in_1 & ~sync_in_0;
  assign edge_any = edge0 | edge1;

  // Phase 1 pairs the previous word's late sample with the current word's early sample.
  always_comb begin
    lane0_d = d1_reg.s0;
    lane0_o = d1_reg.o0;
    lane0_y = d1_reg.y0;
    lane1_d = d1_reg.s1;
    lane1_o = d1_reg.o1;
    lane1_y = d1_reg.y1;
    if (phase_reg) begin
      lane0_d = d2_s1_reg;
      lane0_o = d2_o1_reg;
      lane0_y = d2_y1_reg;
      lane1_d = d1_reg.s0;
      lane1_o = d1_reg.o0;
      lane1_y = d1_reg.y0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (user_rst) begin
      d1_reg          <= '0;
      d2_s1_reg       <= '0;
      d2_o1_reg       <= '0;
      d2_y1_reg       <= 1'b0;
      prev_sync_1_reg <= 1'b0;
      dout_0          <= '0;
      dout_1          <= '0;
      ovr_out_0       <= '0;
      ovr_out_1       <= '0;
      out_y1_reg      <= 1'b0;
      sync_out        <= 1'b0;
    end else begin
      d1_reg          <= in_word;
      d2_s1_reg       <= d1_reg.s1;
      d2_o1_reg       <= d1_reg.o1;
      d2_y1_reg       <= d1_reg.y1;
      prev_sync_1_reg <= sync_in_1;
      dout_0          <= lane0_d;
      dout_1          <= lane1_d;
      ovr_out_0       <= lane0_o;
      ovr_out_1       <= lane1_o;
      out_y1_reg      <= lane1_y;
      // The sample preceding lane 0 is the lane-1 sample of the word currently on the output.
      sync_out        <= lane0_y & ~out_y1_reg;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (user_rst) begin
      state_reg <= ST_IDLE;
      phase_reg <= 1'b0;
      cnt_reg   <= '0;
      err_count <= '0;
    end else if (arm) begin
      state_reg <= ST_ARMED;
    end else begin
      case (state_reg)
        ST_IDLE: ;
        ST_ARMED: begin
          if (edge_any) begin
            state_reg <= ST_LOCKED;
            phase_reg <= edge1;
            cnt_reg   <= '0;
          end
        end
        ST_LOCKED: begin
          if (CHECK_EN) begin
            if ((edge_any && (cnt_reg != CNT_LAST || edge1 != phase_reg)) ||
                (!edge_any && cnt_reg == CNT_LAST)) begin
              state_reg <= ST_ERROR;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (edge_any) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_reg;
  assign phase = phase_reg;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_ovr
    assign ovr_hit[gi] = ovr_out_0[gi] | ovr_out_1[gi];
    assign ovr_count[gi*OVR_CNT_W +: OVR_CNT_W] = ovr_cnt_reg[gi];
  end

  // A clear coinciding with a fresh overrange restarts the count at one rather than zero.
  always_ff @(posedge adc_clk) begin
    if (user_rst) begin
      ovr_sticky_reg <= '0;
      for (int c = 0; c < NCHAN; c++) ovr_cnt_reg[c] <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (ovr_clear) begin
          ovr_sticky_reg[c] <= ovr_hit[c];
          ovr_cnt_reg[c]    <= ovr_hit[c] ? OVR_CNT_W'(1) : '0;
        end else if (ovr_hit[c]) begin
          ovr_sticky_reg[c] <= 1'b1;
          if (ovr_cnt_reg[c] != '1) ovr_cnt_reg[c] <= ovr_cnt_reg[c] + 1'b1;
        end
      end
    end
  end

  assign ovr_sticky = ovr_sticky_reg;

endmodule
